// File: rtl/sram_req_responder.sv
// Request/response front end for a single-port synchronous SRAM macro.
// Clears the macro after reset, then serves one write or read at a time.
module sram_req_responder #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          mem_en,
    output logic          mem_wen,
    output logic          mem_ren,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          init_done
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WR,
        S_RD,
        S_RSP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd_wait_q, rd_wait_d;
    logic          rd_err_q, rd_err_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          init_done_q, init_done_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_wen_q, mem_wen_d;
    logic          mem_ren_q, mem_ren_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          req_in_range_c;

    assign req_in_range_c = (32'(req_addr) < DEPTH);

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_wait_d   = rd_wait_q;
        rd_err_d    = rd_err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        init_done_d = init_done_q;
        mem_en_d    = 1'b0;
        mem_wen_d   = 1'b0;
        mem_ren_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_INIT: begin
                if (32'(cnt_q) < DEPTH) begin
                    mem_en_d    = 1'b1;
                    mem_wen_d   = 1'b1;
                    mem_addr_d  = AW'(cnt_q);
                    mem_wdata_d = '0;
                    cnt_d       = cnt_q + CW'(1);
                end else begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_valid) begin
                    mem_addr_d = req_addr;
                    mem_en_d   = req_in_range_c;
                    if (req_we) begin
                        state_d     = S_WR;
                        mem_wdata_d = req_wdata;
                        mem_wen_d   = req_in_range_c;
                    end else begin
                        state_d   = S_RD;
                        rd_wait_d = 1'b0;
                        rd_err_d  = ~req_in_range_c;
                        mem_ren_d = req_in_range_c;
                    end
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            // First RD cycle strobes the macro, second waits for its registered data
            S_RD: begin
                if (!rd_wait_q) begin
                    rd_wait_d = 1'b1;
                end else begin
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = rd_err_q;
                    rsp_rdata_d = rd_err_q ? '0 : mem_rdata;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            rd_wait_q   <= 1'b0;
            rd_err_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            init_done_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_wait_q   <= rd_wait_d;
            rd_err_q    <= rd_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            init_done_q <= init_done_d;
            mem_en_q    <= mem_en_d;
            mem_wen_q   <= mem_wen_d;
            mem_ren_q   <= mem_ren_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign init_done = init_done_q;
    assign mem_en    = mem_en_q;
    assign mem_wen   = mem_wen_q;
    assign mem_ren   = mem_ren_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_req_responder.sv
// Directed bench: a full-depth responder (inst 0) and a DEPTH=200 one (inst 1),
// each backed by a simple synchronous SRAM model preloaded with junk.
module tb_sram_req_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_we    [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_rdata [2];
    logic       rsp_err   [2];
    logic       mem_en    [2];
    logic       mem_wen   [2];
    logic       mem_ren   [2];
    logic [7:0] mem_addr  [2];
    logic [7:0] mem_wdata [2];
    logic       init_done [2];
    logic [7:0] mrd0, mrd1;

    int total = 0;
    int bad   = 0;

    sram_req_responder u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .mem_en(mem_en[0]), .mem_wen(mem_wen[0]), .mem_ren(mem_ren[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mrd0),
        .init_done(init_done[0])
    );

    sram_req_responder #(.DEPTH(200)) u_dut200 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .mem_en(mem_en[1]), .mem_wen(mem_wen[1]), .mem_ren(mem_ren[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mrd1),
        .init_done(init_done[1])
    );

    // SRAM models; junk preload makes a missing clear visible
    logic       preload = 1'b1;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    int         both0 = 0;
    int         both1 = 0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem0[i] <= 8'h5A;
            mrd0 <= 8'hEE;
        end else begin
            if (mem_en[0] && mem_wen[0]) mem0[mem_addr[0]] <= mem_wdata[0];
            if (mem_en[0] && mem_ren[0]) mrd0 <= mem0[mem_addr[0]];
        end
        if (mem_wen[0] && mem_ren[0]) both0 <= both0 + 1;
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 8'h5A;
            mrd1 <= 8'hEE;
        end else begin
            if (mem_en[1] && mem_wen[1]) mem1[mem_addr[1]] <= mem_wdata[1];
            if (mem_en[1] && mem_ren[1]) mrd1 <= mem1[mem_addr[1]];
        end
        if (mem_wen[1] && mem_ren[1]) both1 <= both1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs(input int inst);
        return 32'({rsp_valid[inst], rsp_err[inst], init_done[inst], mem_en[inst],
                    mem_wen[inst], mem_ren[inst], req_ready[inst], rsp_rdata[inst],
                    mem_addr[inst], mem_wdata[inst]});
    endfunction

    // Walk the clear sequence of both instances from the first edge after release
    task automatic run_init(input string tag);
        int  p0 = 0;
        int  p1 = 0;
        int  abad = 0;
        bit  done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            tick();
            if (c == 0) begin
                check({tag, "_first_wen"}, 32'(mem_wen[0]), 32'd1);
                check({tag, "_first_addr"}, 32'(mem_addr[0]), 32'd0);
            end
            if (mem_wen[0]) begin
                if (mem_addr[0] != 8'(p0) || mem_wdata[0] != 8'h00 || !mem_en[0] || req_ready[0]) abad++;
                p0++;
            end
            if (mem_wen[1]) begin
                if (mem_addr[1] != 8'(p1) || mem_wdata[1] != 8'h00 || !mem_en[1]) abad++;
                p1++;
            end
            done = init_done[0] && init_done[1];
        end
        check({tag, "_pulses256"}, 32'(p0), 32'd256);
        check({tag, "_pulses200"}, 32'(p1), 32'd200);
        check({tag, "_addr_seq"}, 32'(abad), 32'd0);
        check({tag, "_done_ready"}, 32'({init_done[0], req_ready[0], mem_wen[0]}), 32'b110);
    endtask

    task automatic do_write(input int inst, input logic [7:0] a, input logic [7:0] d,
                            input bit in_rng, input string tag);
        check({tag, "_rdy"}, 32'(req_ready[inst]), 32'd1);
        req_valid[inst] = 1'b1;
        req_we[inst]    = 1'b1;
        req_addr[inst]  = a;
        req_wdata[inst] = d;
        tick();
        req_valid[inst] = 1'b0;
        check({tag, "_strobe"}, 32'({mem_en[inst], mem_wen[inst], mem_ren[inst]}),
              in_rng ? 32'b110 : 32'b000);
        if (in_rng) check({tag, "_addr_data"}, 32'({mem_addr[inst], mem_wdata[inst]}), 32'({a, d}));
        tick();
        check({tag, "_back_idle"}, 32'({req_ready[inst], mem_en[inst], rsp_valid[inst]}), 32'b100);
    endtask

    task automatic do_read(input int inst, input logic [7:0] a, input logic [7:0] exp_d,
                           input bit exp_err, input bit strobe, input string tag);
        rsp_ready[inst] = 1'b1;
        req_valid[inst] = 1'b1;
        req_we[inst]    = 1'b0;
        req_addr[inst]  = a;
        tick();
        req_valid[inst] = 1'b0;
        check({tag, "_strobe"}, 32'({mem_en[inst], mem_wen[inst], mem_ren[inst], rsp_valid[inst]}),
              strobe ? 32'b1010 : 32'b0000);
        tick();
        check({tag, "_lat1"}, 32'({rsp_valid[inst], mem_en[inst]}), 32'd0);
        tick();
        check({tag, "_rsp"}, 32'({rsp_valid[inst], rsp_err[inst], rsp_rdata[inst]}),
              32'({1'b1, exp_err, exp_d}));
        tick();
        check({tag, "_done"}, 32'({rsp_valid[inst], req_ready[inst]}), 32'b01);
    endtask

    initial begin
        int unstable;
        bit found;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b1;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs0", all_outs(0), 32'd0);
        check("reset_outs1", all_outs(1), 32'd0);
        preload = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_init("init");

        do_write(0, 8'h10, 8'hA5, 1'b1, "wr10");
        do_read(0, 8'h10, 8'hA5, 1'b0, 1'b1, "rd10");
        do_read(0, 8'h05, 8'h00, 1'b0, 1'b1, "rd05_cleared");

        // Backpressured response holds while requests are refused
        do_write(0, 8'h20, 8'h3C, 1'b1, "wr20");
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 8'h20;
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        check("hold_first", 32'({rsp_valid[0], rsp_err[0], rsp_rdata[0]}), 32'({2'b10, 8'h3C}));
        unstable     = 0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 8'h21;
        req_wdata[0] = 8'h77;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (!rsp_valid[0] || rsp_err[0] || rsp_rdata[0] != 8'h3C || req_ready[0] || mem_en[0])
                unstable++;
        end
        check("hold_stable", 32'(unstable), 32'd0);
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        tick();
        check("hold_release", 32'({rsp_valid[0], req_ready[0]}), 32'b01);
        do_read(0, 8'h21, 8'h00, 1'b0, 1'b1, "rd21_ignored");

        do_write(1, 8'hC8, 8'h99, 1'b0, "wr_oor");
        do_read(1, 8'hC8, 8'h00, 1'b1, 1'b0, "rd_oor");
        do_write(1, 8'hC7, 8'h42, 1'b1, "wr_last");
        do_read(1, 8'hC7, 8'h42, 1'b0, 1'b1, "rd_last");

        // Reset while a response is pending
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 8'h10;
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        check("rsp_before_rst", 32'({rsp_valid[0], rsp_rdata[0]}), 32'({1'b1, 8'hA5}));
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_rsp", all_outs(0), 32'd0);
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the clear sequence at address 0x80
        tick();
        check("restart_addr0", 32'({mem_wen[0], mem_addr[0]}), 32'({1'b1, 8'h00}));
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            if (mem_wen[0] && mem_addr[0] == 8'h80) found = 1'b1;
            else tick();
        end
        check("reach_init_80", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_init", all_outs(0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_init("reinit");
        do_read(0, 8'h10, 8'h00, 1'b0, 1'b1, "rd10_after_rst");

        check("wen_ren_excl0", 32'(both0), 32'd0);
        check("wen_ren_excl1", 32'(both1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
